// File: rtl/sipo_vec_loader.sv
`default_nettype none
// ============================================================================
// Module  : sipo_vec_loader
// Brief   : Assembles a byte stream into NINPUTS words of IWIDTH bits (LSB
//           byte first) and presents them as a parallel vector with
//           valid/ready. Optional inter-byte timeout via SIPO_TIMEOUT_EN.
// Revision: 1.0 - initial release
// ============================================================================
module sipo_vec_loader #(
    parameter int IWIDTH         = 10,
    parameter int NINPUTS        = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [7:0]                 rx_data,
    input  logic                       rx_valid,
    input  logic                       vec_ready,
    output logic [IWIDTH-1:0]          vec_out [NINPUTS-1:0],
    output logic                       vec_valid,
    output logic [$clog2(NINPUTS)-1:0] word_idx,
    output logic                       overrun
);

    localparam int c_BPW  = (IWIDTH + 7) / 8;
    localparam int c_BCW  = (c_BPW > 1) ? $clog2(c_BPW) : 1;
    localparam int c_EXTW = 8 * c_BPW;
    localparam int c_IDXW = $clog2(NINPUTS);
    localparam logic [c_BCW-1:0]  c_LAST_BYTE = c_BCW'(c_BPW - 1);
    localparam logic [c_IDXW-1:0] c_LAST_WORD = c_IDXW'(NINPUTS - 1);

    if (IWIDTH < 1 || IWIDTH > 32) begin : g_bad_iwidth
        $error("sipo_vec_loader: IWIDTH must be in 1..32");
    end
    if (NINPUTS < 2) begin : g_bad_ninputs
        $error("sipo_vec_loader: NINPUTS must be at least 2");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("sipo_vec_loader: TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [0:0] {
        ST_COLLECT = 1'b0,
        ST_HOLD    = 1'b1
    } state_t;

    state_t             r_state;
    logic [c_BCW-1:0]   r_byte_cnt;
    logic [IWIDTH-1:0]  r_asm;
    logic [IWIDTH-1:0]  w_word;
    logic               w_to_fire;

    // Bits of the incoming byte beyond IWIDTH fall off in the truncating cast.
    always_comb begin
        w_word = r_asm | IWIDTH'(c_EXTW'(rx_data) << {r_byte_cnt, 3'b000});
    end

`ifdef SIPO_TIMEOUT_EN
    localparam int c_TOW = ($clog2(TIMEOUT_CYCLES) > 0) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [c_TOW-1:0] r_to_cnt;
    logic             w_partial;

    always_comb begin
        w_partial = (r_byte_cnt != '0) || (word_idx != '0);
        w_to_fire = (r_state == ST_COLLECT) && !rx_valid && w_partial &&
                    (r_to_cnt == c_TOW'(TIMEOUT_CYCLES - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_to_cnt <= '0;
        end else if (r_state != ST_COLLECT || rx_valid || w_to_fire) begin
            r_to_cnt <= '0;
        end else if (w_partial) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end
`else
    always_comb begin
        w_to_fire = 1'b0;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_COLLECT;
            for (int i = 0; i < NINPUTS; i++) begin
                vec_out[i] <= '0;
            end
            vec_valid  <= 1'b0;
            word_idx   <= '0;
            overrun    <= 1'b0;
            r_byte_cnt <= '0;
            r_asm      <= '0;
        end else begin
            case (r_state)
                ST_COLLECT: begin
                    if (rx_valid) begin
                        if (r_byte_cnt == c_LAST_BYTE) begin
                            vec_out[word_idx] <= w_word;
                            r_byte_cnt        <= '0;
                            r_asm             <= '0;
                            if (word_idx == c_LAST_WORD) begin
                                word_idx  <= '0;
                                vec_valid <= 1'b1;
                                r_state   <= ST_HOLD;
                            end else begin
                                word_idx <= word_idx + 1'b1;
                            end
                        end else begin
                            r_asm      <= w_word;
                            r_byte_cnt <= r_byte_cnt + 1'b1;
                        end
                    end else if (w_to_fire) begin
                        // Abandon the partial vector; stored elements stay as they are.
                        r_byte_cnt <= '0;
                        r_asm      <= '0;
                        word_idx   <= '0;
                    end
                end
                ST_HOLD: begin
                    if (rx_valid) begin
                        overrun <= 1'b1;
                    end
                    if (vec_ready) begin
                        vec_valid <= 1'b0;
                        r_state   <= ST_COLLECT;
                    end
                end
                default: begin
                    r_state <= ST_COLLECT;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sipo_vec_loader.sv
`default_nettype none
// ============================================================================
// Module  : tb_sipo_vec_loader
// Brief   : Self-checking bench for sipo_vec_loader (IWIDTH=10, NINPUTS=8).
// Revision: 1.0 - initial release
// ============================================================================
module tb_sipo_vec_loader;

    localparam int IW = 10;
    localparam int NI = 8;
    localparam int TO = 50;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [7:0]            rx_data;
    logic                  rx_valid;
    logic                  vec_ready;
    logic [IW-1:0]         vec_out [NI-1:0];
    logic                  vec_valid;
    logic [$clog2(NI)-1:0] word_idx;
    logic                  overrun;

    sipo_vec_loader #(
        .IWIDTH        (IW),
        .NINPUTS       (NI),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .vec_ready(vec_ready),
        .vec_out  (vec_out),
        .vec_valid(vec_valid),
        .word_idx (word_idx),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: the bytes of the vector in progress, the element store,
    // a hold flag, the sticky overrun and an idle counter.
    byte unsigned  m_q[$];
    int            m_mem [NI];
    bit            m_hold;
    bit            m_ovr;
    int            m_idle;

    function automatic void model_reset();
        m_q.delete();
        for (int i = 0; i < NI; i++) m_mem[i] = 0;
        m_hold = 0;
        m_ovr  = 0;
        m_idle = 0;
    endfunction

    function automatic void model_step(bit r, bit v, byte unsigned d, bit rdy);
        if (r) begin
            model_reset();
            return;
        end
        if (m_hold) begin
            if (v) m_ovr = 1;
            if (rdy) m_hold = 0;
            return;
        end
        if (v) begin
            m_idle = 0;
            m_q.push_back(d);
            if (m_q.size() % 2 == 0) begin
                int k;
                k = m_q.size() / 2 - 1;
                m_mem[k] = (int'(m_q[2*k]) + 256 * int'(m_q[2*k+1])) % (1 << IW);
                if (k == NI - 1) begin
                    m_hold = 1;
                    m_q.delete();
                end
            end
        end
`ifdef SIPO_TIMEOUT_EN
        else if (m_q.size() != 0) begin
            if (m_idle == TO - 1) begin
                m_q.delete();
                m_idle = 0;
            end else begin
                m_idle++;
            end
        end
`endif
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("vec_valid", 64'(vec_valid), 64'(m_hold));
        chk("word_idx", 64'(word_idx), 64'(m_q.size() / 2));
        chk("overrun", 64'(overrun), 64'(m_ovr));
        for (int i = 0; i < NI; i++)
            chk($sformatf("vec_out[%0d]", i), 64'(vec_out[i]), 64'(m_mem[i]));
    endtask

    task automatic cyc(input bit r, input bit v, input byte unsigned d, input bit rdy);
        rst       = r;
        rx_valid  = v;
        rx_data   = d;
        vec_ready = rdy;
        @(posedge clk);
        model_step(r, v, d, rdy);
        #1;
        check_model();
    endtask

    typedef struct {
        bit           r;
        bit           v;
        byte unsigned d;
        bit           rdy;
        bit           e_valid;
        int           e_idx;
        bit           e_ovr;
    } vec_t;

    vec_t tbl [8];

    initial begin
        int           first_valid;
        byte unsigned b;
        int           exp0;

        tbl[0] = '{1, 0, 8'h00, 0, 0, 0, 0};
        tbl[1] = '{1, 0, 8'h00, 0, 0, 0, 0};
        tbl[2] = '{0, 1, 8'h34, 0, 0, 0, 0};
        tbl[3] = '{0, 1, 8'h02, 0, 0, 1, 0};
        tbl[4] = '{0, 0, 8'h00, 0, 0, 1, 0};
        tbl[5] = '{0, 1, 8'hFF, 0, 0, 1, 0};
        tbl[6] = '{0, 1, 8'hFF, 0, 0, 2, 0};
        tbl[7] = '{0, 0, 8'h00, 1, 0, 2, 0};

        model_reset();
        rst = 1; rx_valid = 0; rx_data = 0; vec_ready = 0;

        // Reset, first two words, vec_ready ignored while collecting
        for (int i = 0; i < 8; i++) begin
            cyc(tbl[i].r, tbl[i].v, tbl[i].d, tbl[i].rdy);
            chk("tbl_valid", 64'(vec_valid), 64'(tbl[i].e_valid));
            chk("tbl_idx", 64'(word_idx), 64'(tbl[i].e_idx));
            chk("tbl_ovr", 64'(overrun), 64'(tbl[i].e_ovr));
        end

        // Remaining six zero words complete the first vector
        for (int i = 0; i < 12; i++) cyc(0, 1, 8'h00, 0);
        chk("full_valid", 64'(vec_valid), 64'd1);
        chk("full_e0", 64'(vec_out[0]), 64'h234);
        chk("full_e1", 64'(vec_out[1]), 64'h3FF);
        chk("full_e7", 64'(vec_out[7]), 64'h0);
        for (int i = 0; i < 20; i++) cyc(0, 0, 8'h00, 0);
        chk("hold_valid", 64'(vec_valid), 64'd1);
        chk("hold_e0", 64'(vec_out[0]), 64'h234);

        // Handshake, then a second vector
        cyc(0, 0, 8'h00, 1);
        chk("ack_valid", 64'(vec_valid), 64'd0);
        chk("ack_idx", 64'(word_idx), 64'd0);
        for (int i = 0; i < 16; i++) cyc(0, 1, 8'($urandom), 0);
        chk("second_valid", 64'(vec_valid), 64'd1);

        // Overrun while holding, including the acknowledge cycle
        cyc(0, 1, 8'hAA, 0);
        chk("ovr_set", 64'(overrun), 64'd1);
        cyc(0, 1, 8'hAA, 1);
        chk("ovr_ack_valid", 64'(vec_valid), 64'd0);
        chk("ovr_ack_idx", 64'(word_idx), 64'd0);
        cyc(0, 1, 8'h11, 0);
        cyc(0, 1, 8'h01, 0);
        chk("ovr_e0", 64'(vec_out[0]), 64'h111);
        chk("ovr_idx", 64'(word_idx), 64'd1);
        for (int i = 0; i < 5; i++) cyc(0, 0, 8'h00, 0);
        chk("ovr_sticky", 64'(overrun), 64'd1);

        // Reset mid-vector
        for (int i = 0; i < 5; i++) cyc(0, 1, 8'($urandom), 0);
        cyc(1, 0, 8'h00, 0);
        chk("rst_idx", 64'(word_idx), 64'd0);
        chk("rst_ovr", 64'(overrun), 64'd0);
        for (int i = 0; i < 16; i++) cyc(0, 1, 8'($urandom), 0);
        chk("rst_vec_valid", 64'(vec_valid), 64'd1);
        cyc(0, 0, 8'h00, 1);

        // Partial burst, long idle, full burst
        cyc(0, 1, 8'h5A, 0);
        cyc(0, 1, 8'h01, 0);
        cyc(0, 1, 8'h7C, 0);
        for (int i = 0; i < 60; i++) cyc(0, 0, 8'h00, 0);
        first_valid = 0;
        for (int n = 1; n <= 16; n++) begin
            b = (n == 1) ? 8'h21 : (n == 2) ? 8'h03 : 8'($urandom);
            cyc(0, 1, b, 0);
            if (vec_valid && first_valid == 0) first_valid = n;
        end
`ifdef SIPO_TIMEOUT_EN
        exp0 = 'h321;
        chk("timeout_bytes", 64'(first_valid), 64'd16);
`else
        exp0 = 'h15A;
        chk("timeout_bytes", 64'(first_valid), 64'd13);
`endif
        chk("timeout_e0", 64'(vec_out[0]), 64'(exp0));
        cyc(0, 0, 8'h00, 1);

        // Randomised traffic against the model
        for (int i = 0; i < 4000; i++) begin
            cyc(($urandom_range(0, 399) == 0), ($urandom_range(0, 1) == 1),
                8'($urandom), ($urandom_range(0, 3) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sipo_vec_loader.md
Name: sipo_vec_loader

Overview:
- Upstream feeder for the parallel-in/serial-out vector memory.
- Collects a UART byte stream and assembles NINPUTS words of IWIDTH bits each, sent LSB byte first.
- Presents the words as one parallel vector with a valid/ready handshake; vec_valid && vec_ready drives the memory's load strobe.
- Element 0 is the first word received.

Parameters:
- IWIDTH, 10: bits per word; must be in 1..32.
- NINPUTS, 8: words per vector; must be at least 2.
- TIMEOUT_CYCLES, 100000: inter-byte timeout in clock cycles. Used only with SIPO_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- rx_data  in  8  received byte.
- rx_valid  in  1  one-cycle strobe; rx_data is valid in that cycle.
- vec_ready  in  1  downstream accepts the vector this cycle.
- vec_out  out  IWIDTH x NINPUTS (unpacked, index NINPUTS-1:0)  assembled vector, registered.
- vec_valid  out  1  vector complete and held.
- word_idx  out  $clog2(NINPUTS)  index of the word currently being assembled.
- overrun  out  1  sticky; a byte was dropped.

Behaviour:
- Clocking and reset:
  - One clock: clk. Reset rst is synchronous and active-high.
  - Reset clears all vec_out elements, vec_valid, word_idx, overrun, byte counter and assembly register, and enters ST_COLLECT.
  - Reset mid-vector discards the partial data.
- Derived constant: BPW = ceil(IWIDTH/8) bytes per word.
- State ST_COLLECT:
  - On rx_valid, the byte goes to assembly bits [8*b+7:8*b], where b = byte_cnt.
  - Then byte_cnt increments.
  - If b == BPW-1, the word is complete:
    - the element vec_out[word_idx] is written with {current byte, assembly}[IWIDTH-1:0]; upper excess bits are discarded;
    - byte_cnt and the assembly register clear;
    - word_idx increments.
  - When the completed word is word_idx == NINPUTS-1:
    - go to ST_HOLD;
    - vec_valid rises on the same edge that writes the last element, so the full vector is visible with vec_valid;
    - word_idx wraps to 0.
  - vec_valid is 0 in this state.
- State ST_HOLD:
  - vec_valid = 1; vec_out is frozen.
  - On vec_ready, vec_valid drops at the next edge and the block returns to ST_COLLECT with counters at 0.
  - vec_out keeps its values until each element is overwritten.
  - Any rx_valid in ST_HOLD drops its byte and sets overrun. This includes the cycle in which vec_ready is high.
- vec_ready is ignored in ST_COLLECT.
- Elements not yet rewritten in a new collection retain old values; downstream only samples while vec_valid.
- Latency: vec_valid rises 1 cycle after the rx_valid of the final byte.
- overrun clears only on rst.
- IWIDTH <= 8: BPW = 1; each byte is one word, truncated.

Optional Feature:
- Macro: SIPO_TIMEOUT_EN.
- Defined:
  - A counter in ST_COLLECT resets on every rx_valid and increments otherwise, only while byte_cnt != 0 or word_idx != 0.
  - On reaching TIMEOUT_CYCLES-1, the counter, byte_cnt, word_idx and assembly all clear. The partial vector is discarded; vec_out elements are not cleared.
  - The counter is inactive in ST_HOLD.
- Not defined: no counter; the block waits indefinitely for the remaining bytes.

Test Plan (IWIDTH=10, NINPUTS=8 unless noted):
- Reset: rst high 2 cycles → vec_valid=0, word_idx=0, overrun=0, all vec_out=0.
- Full vector: send byte pairs (0x34,0x02), (0xFF,0xFF), then (0x00,0x00)x6, with vec_ready=0 → one cycle after the 16th byte vec_valid=1, vec_out[0]=0x234, vec_out[1]=0x3FF (truncation), others 0. The vector holds for 20 cycles.
- Handshake: from ST_HOLD pulse vec_ready for 1 cycle → vec_valid=0 next cycle, word_idx=0. A new 16-byte vector then produces a second vec_valid.
- Overrun: in ST_HOLD send rx_valid with 0xAA, including in the same cycle as vec_ready → overrun=1 and stays 1; next vector element 0 comes from the following bytes only.
- Reset mid-operation: send 5 bytes, assert rst → word_idx=0, byte_cnt=0. The next 16 bytes form a correct vector.
- Timeout (SIPO_TIMEOUT_EN, TIMEOUT_CYCLES=50): send 3 bytes, idle 60 cycles, then 16 bytes → a single vec_valid; vec_out[0] equals the first pair of the 16 bytes. Without the macro the same stimulus yields vec_valid after 13 bytes of the second burst.
